// File: rtl/trigger_buffer_manager_pkg.sv
// rtl/trigger_buffer_manager_pkg.sv - shared state encoding and width helper for the trigger buffer manager
package trigger_buffer_manager_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } state_e;

  // Index width for a buffer count; never below one bit so vectors stay legal.
  function automatic int buf_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trigger_buffer_manager_if.sv
// rtl/trigger_buffer_manager_if.sv - event generator link: digitize report out, buffer release in
interface trigger_buffer_manager_if
  import trigger_buffer_manager_pkg::*;
#(
  parameter int NUM_BUF = 4,
  parameter int NUM_SRC = 4
);
  localparam int BUF_BITS = buf_bits(NUM_BUF);

  logic                clear_i;
  logic [BUF_BITS-1:0] clear_buffer_i;
  logic                digitize_o;
  logic [BUF_BITS-1:0] digitize_buffer_o;
  logic [NUM_SRC-1:0]  digitize_source_o;
  logic [NUM_BUF-1:0]  buffer_status_o;

  // Buffer manager side.
  modport master (
    input  clear_i, clear_buffer_i,
    output digitize_o, digitize_buffer_o, digitize_source_o, buffer_status_o
  );

  // Event generator side.
  modport slave (
    output clear_i, clear_buffer_i,
    input  digitize_o, digitize_buffer_o, digitize_source_o, buffer_status_o
  );
endinterface

// File: rtl/trigger_buffer_manager_sat_counter.sv
// rtl/trigger_buffer_manager_sat_counter.sv - saturating per-second event counter with PPS snapshot
module sat_counter #(
  parameter int CNT_BITS = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                inc_i,
  input  logic                pps_i,
  output logic [CNT_BITS-1:0] count_o
);

  logic [CNT_BITS-1:0] run_q;
  logic [CNT_BITS-1:0] count_q;

  // On PPS publish the finished second and restart, counting the PPS cycle's own event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q   <= '0;
      count_q <= '0;
    end else if (pps_i) begin
      count_q <= run_q;
      run_q   <= {{(CNT_BITS-1){1'b0}}, inc_i};
    end else if (inc_i && (run_q != {CNT_BITS{1'b1}})) begin
      run_q   <= run_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/trigger_buffer_manager.sv
// rtl/trigger_buffer_manager.sv - round-robin hold buffer allocation with holdoff and dead/drop accounting
module trigger_buffer_manager
  import trigger_buffer_manager_pkg::*;
#(
  parameter int NUM_BUF      = 4,
  parameter int NUM_SRC      = 4,
  parameter int HOLDOFF_BITS = 8,
  parameter int CNT_BITS     = 32
) (
  input  logic                    clk250_i,
  input  logic                    rst_n_i,
  input  logic [NUM_SRC-1:0]      trig_i,
  input  logic [NUM_SRC-1:0]      trig_mask_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic                    pps_i,
  output logic [NUM_BUF-1:0]      HOLD_o,
  output logic                    dead_o,
  output logic [CNT_BITS-1:0]     dead_count_o,
  output logic [CNT_BITS-1:0]     drop_count_o,
  trigger_buffer_manager_if.master evt_if
);

  localparam int BUF_BITS = buf_bits(NUM_BUF);

  state_e                  state_q;
  logic [HOLDOFF_BITS-1:0] cnt_q;
  logic [BUF_BITS-1:0]     wr_ptr_q;
  logic [NUM_BUF-1:0]      hold_q, hold_d;
  logic                    qual_q;
  logic                    digitize_q;
  logic [BUF_BITS-1:0]     dig_buf_q;
  logic [NUM_SRC-1:0]      dig_src_q;

  logic [NUM_SRC-1:0] src_masked;
  logic               qual, trig_edge, dead_w, accept, drop;

  assign src_masked = trig_i & ~trig_mask_i;
  assign qual       = |src_masked;
  assign trig_edge  = qual & ~qual_q;
  // Dead uses the pre-clear hold bit, so a clear landing with an edge cannot rescue that edge.
  assign dead_w     = (state_q == HOLDOFF) | hold_q[wr_ptr_q];
  assign accept     = trig_edge & ~dead_w;
  assign drop       = trig_edge & dead_w;

  // Next hold vector: release first, then claim; they never collide since claiming needs a free buffer.
  always_comb begin
    hold_d = hold_q;
    if (evt_if.clear_i) hold_d[evt_if.clear_buffer_i] = 1'b0;
    if (accept)         hold_d[wr_ptr_q] = 1'b1;
  end

  // Hold bits and the previous qualified level used for edge detection.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q <= '0;
      qual_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      qual_q <= qual;
    end
  end

  // Allocation FSM: accept in IDLE, then sit out holdoff_i+1 cycles in HOLDOFF.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      digitize_q <= 1'b0;
      dig_buf_q  <= '0;
      dig_src_q  <= '0;
    end else begin
      digitize_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            digitize_q <= 1'b1;
            dig_buf_q  <= wr_ptr_q;
            dig_src_q  <= src_masked;
            wr_ptr_q   <= wr_ptr_q + {{(BUF_BITS-1){1'b0}}, 1'b1};
            cnt_q      <= holdoff_i;
            state_q    <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - {{(HOLDOFF_BITS-1){1'b0}}, 1'b1};
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_BITS(CNT_BITS)) u_dead_cnt (
    .clk_i   (clk250_i),
    .rst_n_i (rst_n_i),
    .inc_i   (dead_w),
    .pps_i   (pps_i),
    .count_o (dead_count_o)
  );

  sat_counter #(.CNT_BITS(CNT_BITS)) u_drop_cnt (
    .clk_i   (clk250_i),
    .rst_n_i (rst_n_i),
    .inc_i   (drop),
    .pps_i   (pps_i),
    .count_o (drop_count_o)
  );

  assign HOLD_o                   = hold_q;
  assign dead_o                   = dead_w;
  assign evt_if.digitize_o        = digitize_q;
  assign evt_if.digitize_buffer_o = dig_buf_q;
  assign evt_if.digitize_source_o = dig_src_q;
  assign evt_if.buffer_status_o   = hold_q;

endmodule

// File: tb/tb_trigger_buffer_manager.sv
// tb/tb_trigger_buffer_manager.sv - directed bench with digitize scoreboard for trigger_buffer_manager
module tb_trigger_buffer_manager;
  localparam int NB = 4;
  localparam int NS = 4;
  localparam int HB = 8;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] trig, mask;
  logic [HB-1:0] holdoff;
  logic          pps;
  logic [NB-1:0] hold;
  logic          dead;
  logic [CB-1:0] dead_cnt, drop_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int           cyc;
    logic [1:0]   idx;
    logic [NS-1:0] src;
    logic [NB-1:0] hold;
  } exp_t;
  exp_t sb[$];

  trigger_buffer_manager_if #(.NUM_BUF(NB), .NUM_SRC(NS)) evt_if ();

  trigger_buffer_manager #(
    .NUM_BUF(NB), .NUM_SRC(NS), .HOLDOFF_BITS(HB), .CNT_BITS(CB)
  ) dut (
    .clk250_i     (clk),
    .rst_n_i      (rst_n),
    .trig_i       (trig),
    .trig_mask_i  (mask),
    .holdoff_i    (holdoff),
    .pps_i        (pps),
    .HOLD_o       (hold),
    .dead_o       (dead),
    .dead_count_o (dead_cnt),
    .drop_count_o (drop_cnt),
    .evt_if       (evt_if)
  );

  always #2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [1:0] idx, input logic [NS-1:0] src, input logic [NB-1:0] h);
    exp_t e;
    e.cyc = cyc + 1;
    e.idx = idx;
    e.src = src;
    e.hold = h;
    sb.push_back(e);
  endtask

  task automatic trig_pulse(input logic [NS-1:0] src);
    trig = src;
    tick();
    trig = '0;
    ticks(7);
  endtask

  task automatic pps_pulse();
    pps = 1'b1;
    tick();
    pps = 1'b0;
  endtask

  task automatic clear_buf(input logic [1:0] idx);
    evt_if.clear_i = 1'b1;
    evt_if.clear_buffer_i = idx;
    tick();
    evt_if.clear_i = 1'b0;
  endtask

  // Every digitize pulse must match the oldest expected event, including its cycle.
  always @(negedge clk) begin
    if (rst_n && evt_if.digitize_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_digitize", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("digitize_cycle", cyc, e.cyc);
        chk("digitize_buffer", {30'd0, evt_if.digitize_buffer_o}, {30'd0, e.idx});
        chk("digitize_source", {28'd0, evt_if.digitize_source_o}, {28'd0, e.src});
        chk("buffer_status", {28'd0, evt_if.buffer_status_o}, {28'd0, e.hold});
      end
    end
  end

  initial begin
    rst_n = 1'b0; trig = '0; mask = '0; holdoff = 8'd3; pps = 1'b0;
    evt_if.clear_i = 1'b0; evt_if.clear_buffer_i = '0;
    ticks(3);
    chk("rst_hold", {28'd0, hold}, 32'd0);
    chk("rst_dead", {31'd0, dead}, 32'd0);
    chk("rst_digitize", {31'd0, evt_if.digitize_o}, 32'd0);
    chk("rst_dbuf", {30'd0, evt_if.digitize_buffer_o}, 32'd0);
    chk("rst_dsrc", {28'd0, evt_if.digitize_source_o}, 32'd0);
    chk("rst_status", {28'd0, evt_if.buffer_status_o}, 32'd0);
    chk("rst_dead_cnt", {24'd0, dead_cnt}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single trigger, holdoff 3 -> four dead cycles starting at digitize
    trig = 4'b0001;
    push(2'd0, 4'b0001, 4'b0001);
    tick();
    trig = '0;
    chk("t1_hold", {28'd0, hold}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_dead_holdoff", {31'd0, dead}, 32'd1);
      tick();
    end
    chk("t1_dead_released", {31'd0, dead}, 32'd0);
    chk("t1_digitize_one_cycle", {31'd0, evt_if.digitize_o}, 32'd0);

    // fill the remaining buffers, then a fifth trigger is dropped
    push(2'd1, 4'b0001, 4'b0011); trig_pulse(4'b0001);
    push(2'd2, 4'b0001, 4'b0111); trig_pulse(4'b0001);
    push(2'd3, 4'b0001, 4'b1111); trig_pulse(4'b0001);
    chk("full_hold", {28'd0, hold}, 32'hF);
    chk("full_dead", {31'd0, dead}, 32'd1);
    pps_pulse();
    trig_pulse(4'b0001);
    pps_pulse();
    chk("full_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    chk("full_still_dead", {31'd0, dead}, 32'd1);
    ticks(9);
    pps_pulse();
    chk("dead_cnt_window", {24'd0, dead_cnt}, 32'd10);
    chk("drop_cnt_quiet", {24'd0, drop_cnt}, 32'd0);

    // out-of-order clears; allocation resumes at buffer 0
    clear_buf(2'd2);
    chk("clr2_hold", {28'd0, hold}, 32'hB);
    clear_buf(2'd0);
    chk("clr0_hold", {28'd0, hold}, 32'hA);
    chk("clr0_not_dead", {31'd0, dead}, 32'd0);
    push(2'd0, 4'b0001, 4'b1011); trig_pulse(4'b0001);
    chk("blocked_at_wr_ptr1", {31'd0, dead}, 32'd1);
    chk("dbuf_held", {30'd0, evt_if.digitize_buffer_o}, 32'd0);

    // masking
    clear_buf(2'd1);
    chk("clr1_hold", {28'd0, hold}, 32'h9);
    mask = 4'b0001; trig = 4'b0011;
    push(2'd1, 4'b0010, 4'b1011);
    ticks(7);
    trig = 4'b0001;
    ticks(3);
    trig = '0;
    ticks(2);
    chk("mask_no_extra_hold", {28'd0, hold}, 32'hB);
    chk("mask_dsrc_held", {28'd0, evt_if.digitize_source_o}, 32'h2);
    trig = 4'b0001;
    tick();
    mask = '0;
    push(2'd2, 4'b0001, 4'b1111);
    ticks(7);
    trig = '0;
    tick();

    // clear and edge together on wr_ptr's held buffer
    pps_pulse();
    evt_if.clear_i = 1'b1; evt_if.clear_buffer_i = 2'd3; trig = 4'b0001;
    tick();
    evt_if.clear_i = 1'b0; trig = '0;
    chk("coincide_hold", {28'd0, hold}, 32'h7);
    chk("coincide_no_digitize", {31'd0, evt_if.digitize_o}, 32'd0);
    ticks(2);
    pps_pulse();
    chk("coincide_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    chk("coincide_free_after", {31'd0, dead}, 32'd0);

    // saturation of the dead counter while full
    push(2'd3, 4'b0001, 4'b1111); trig_pulse(4'b0001);
    pps_pulse();
    ticks(300);
    pps_pulse();
    chk("dead_cnt_saturated", {24'd0, dead_cnt}, 32'hFF);
    ticks(4);
    pps_pulse();
    chk("dead_cnt_restart_at_1", {24'd0, dead_cnt}, 32'd5);

    // zero holdoff: triggers two cycles apart are both accepted
    for (int i = 0; i < 4; i++) clear_buf(2'(i));
    chk("all_cleared", {28'd0, hold}, 32'd0);
    holdoff = 8'd0;
    push(2'd0, 4'b0010, 4'b0001);
    trig = 4'b0010; tick(); trig = '0; tick();
    push(2'd1, 4'b0010, 4'b0011);
    trig = 4'b0010; tick(); trig = '0; tick();
    ticks(3);
    chk("h0_dbuf", {30'd0, evt_if.digitize_buffer_o}, 32'd1);
    chk("h0_hold", {28'd0, hold}, 32'h3);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trigger_buffer_manager.md
Name: trigger_buffer_manager

Overview:
- Parametrised successor to the fixed 4-buffer, 4-source trigger buffer manager.
- Accepts NUM_SRC maskable trigger sources and allocates NUM_BUF hold buffers in strict round-robin order.
- Applies a programmable post-trigger holdoff and counts dead cycles and dropped triggers per PPS second.
- Sits between the RF/PPS/soft trigger sources and the event generator / SURF HOLD lines, all in the 250 MHz domain.

Parameters:
- NUM_BUF, 4, number of hold buffers; power of 2, 2..16.
- NUM_SRC, 4, number of trigger sources; 1..8.
- HOLDOFF_BITS, 8, width of holdoff_i.
- CNT_BITS, 32, width of dead-time and dropped-trigger counters.

Ports:
- clk250_i  in  1  system clock, 250 MHz.
- rst_n_i  in  1  asynchronous active-low reset.
- trig_i  in  NUM_SRC  trigger requests, level-sampled every cycle.
- trig_mask_i  in  NUM_SRC  1 = source disabled.
- holdoff_i  in  HOLDOFF_BITS  post-trigger holdoff length in cycles.
- clear_i  in  1  release-buffer strobe.
- clear_buffer_i  in  log2(NUM_BUF)  buffer index to release.
- pps_i  in  1  PPS strobe, one cycle, synchronous to clk250_i.
- HOLD_o  out  NUM_BUF  per-buffer hold.
- digitize_o  out  1  one-cycle pulse per accepted trigger.
- digitize_buffer_o  out  log2(NUM_BUF)  buffer that was held.
- digitize_source_o  out  NUM_SRC  unmasked sources active on the accepting cycle.
- buffer_status_o  out  NUM_BUF  equals HOLD_o; the event generator samples it with digitize_o.
- dead_o  out  1  trigger is not accepted this cycle.
- dead_count_o  out  CNT_BITS  dead cycles in the last completed PPS second.
- drop_count_o  out  CNT_BITS  dropped triggers in the last completed PPS second.

Behaviour:
- Reset (async assert, sync release): all outputs 0, wr_ptr=0, state IDLE, internal counters 0.
- Qualified trigger: qual = |(trig_i & ~trig_mask_i).
- Trigger events are edge-based: only a rising edge of qual counts, so a held-high source fires once.
- State IDLE, dead_o = HOLD_o[wr_ptr]:
  - Edge while not dead: set HOLD_o[wr_ptr] on the next cycle.
  - Same next cycle: digitize_o=1, digitize_buffer_o=wr_ptr (pre-increment), digitize_source_o = masked trig_i from the edge cycle.
  - wr_ptr increments modulo NUM_BUF; go to HOLDOFF with counter = holdoff_i.
  - Latency from edge cycle to digitize_o: exactly 1 cycle.
  - Edge while dead: drop counter +1; no HOLD or digitize.
- State HOLDOFF:
  - dead_o=1; edges are counted as dropped.
  - Counter decrements each cycle; leave to IDLE when it reaches 0.
  - holdoff_i=0 still costs one HOLDOFF cycle, so the minimum trigger spacing is 2 cycles.
  - holdoff_i is sampled only on entry to HOLDOFF.
- digitize_buffer_o and digitize_source_o hold their values until the next accepted trigger.
- Clear:
  - clear_i=1 deasserts HOLD_o[clear_buffer_i] on the next cycle.
  - Clearing a buffer that is not held is a no-op.
  - Clears may arrive out of order; allocation stays strict round-robin, so an un-cleared buffer at wr_ptr blocks even if others are free.
- Simultaneous clear and trigger edge on wr_ptr's buffer: the trigger sees the pre-clear HOLD and is dropped; the clear still takes effect.
- Full (all HOLD set): dead_o=1 until a clear of wr_ptr's buffer.
- Dead counter: +1 every cycle dead_o=1.
- Counters saturate at all-ones and do not wrap.
- pps_i:
  - dead_count_o/drop_count_o load the running counts on the next cycle.
  - Running counters restart, counting the current cycle's event: the new value is 1 if dead/dropped on the pps cycle, else 0.
- Trigger masking changes take effect on the next cycle's qual. Unmasking a source that is already high produces an edge and fires.

Decomposition:
- Shared package: BUF_BITS = $clog2(NUM_BUF) helper and the state encoding (IDLE, HOLDOFF).
- One sub-module, sat_counter: CNT_BITS saturating counter with inc, load-on-pps, and restart-with-value; instantiated twice (dead, drop).

Test Plan:
- Reset, holdoff_i=3, single trig_i[0] pulse → digitize_o 1 cycle later, digitize_buffer_o=0, digitize_source_o=0001, HOLD_o=0001, dead_o high 4 cycles after digitize.
- Five spaced triggers, no clears, NUM_BUF=4 → HOLD_o=1111 after four. Fifth is dropped, drop count=1 after pps, dead_o stays 1.
- From full, clear buffer 2 then buffer 0 → HOLD_o=1010, wr_ptr=0 allocates buffer 0 on the next trigger, digitize_buffer_o=0.
- trig_mask_i=0001 with trig_i=0011 → digitize_source_o=0010. Then trig_i=0001 only → no digitize.
- Clear of buffer 0 coincident with a trigger edge while HOLD_o[0]=1 and wr_ptr=0 → trigger dropped, HOLD_o[0]=0 next cycle.
- Force the dead counter near all-ones, keep dead → dead_count_o=0xFFFFFFFF at pps. pps during a dead cycle → running count restarts at 1.
